// File: rtl/switch_led_arbiter_pkg.sv
// Shared types for the switch/LED arbiter: channel count, index type, FSM states
// and the round-robin pick helper.
package switch_led_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    COOLDOWN
  } state_t;

  // Scans from the highest offset down so the closest set bit to ptr is kept last.
  function automatic ch_idx_t rr_pick(input logic [NUM_CH-1:0] req, input ch_idx_t ptr);
    ch_idx_t idx;
    rr_pick = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + ch_idx_t'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/switch_led_arbiter_if.sv
// Switch-in / LED-out bundle between the pads (master) and the arbiter (slave).
interface switch_led_arbiter_if;

  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       o_LED_1;
  logic       o_LED_2;
  logic       o_LED_3;
  logic       o_LED_4;
  logic [3:0] o_Grant;
  logic       o_Busy;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Grant, o_Busy
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Grant, o_Busy
  );

endinterface

// File: rtl/switch_led_arbiter_debounce_filter.sv
// Per-switch debounce: the stable level follows the raw input only after it has
// differed for DEBOUNCE_LIMIT consecutive cycles.
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Stable
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count    <= '0;
      o_Stable <= 1'b0;
    end else if (i_Raw == o_Stable) begin
      count <= '0;
    end else if (count == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
      o_Stable <= i_Raw;
      count    <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/switch_led_arbiter.sv
// Four debounced switches post sticky toggle requests; a round-robin FSM serves
// one request per slot by inverting the matching LED, then waits out a cooldown.
module switch_led_arbiter
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT  = 250000,
  parameter int COOLDOWN_CYCLES = 25
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  switch_led_arbiter_if.slave bus
);

  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] stable_prev;
  logic [NUM_CH-1:0] release_edge;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] clear_mask;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic [CD_W-1:0]   cd_cnt;
  ch_idx_t           rr_ptr;
  ch_idx_t           served;
  ch_idx_t           pick;
  state_t            state;

  assign raw = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_debounce
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Raw   (raw[i]),
      .o_Stable(stable[i])
    );
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) stable_prev <= '0;
    else       stable_prev <= stable;
  end

  assign release_edge = stable_prev & ~stable;

  always_comb begin
    pick       = rr_pick(pending, rr_ptr);
    clear_mask = '0;
    if (state == SERVE) clear_mask = NUM_CH'(1) << served;
  end

  // A release landing in the same cycle as its own SERVE is OR-ed back in, so set wins.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      pending <= '0;
      rr_ptr  <= '0;
      served  <= '0;
      led     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      cd_cnt  <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | release_edge;
      case (state)
        IDLE: begin
          if (|pending) begin
            served <= pick;
            grant  <= NUM_CH'(1) << pick;
            busy   <= 1'b1;
            state  <= SERVE;
          end
        end
        SERVE: begin
          led[served] <= ~led[served];
          rr_ptr      <= served + ch_idx_t'(1);
          grant       <= '0;
          cd_cnt      <= '0;
          if (COOLDOWN_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cd_cnt == CD_W'(COOLDOWN_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cd_cnt <= cd_cnt + CD_W'(1);
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_LED_1 = led[0];
  assign bus.o_LED_2 = led[1];
  assign bus.o_LED_3 = led[2];
  assign bus.o_LED_4 = led[3];
  assign bus.o_Grant = grant;
  assign bus.o_Busy  = busy;

endmodule
